en_decode_sweep: RTL and testbench

Parametrised, registered N-to-2^N enabled decoder for the register-file write-enable path. In normal mode it produces a one-hot write strobe from a write address one cycle after sampling. A sweep mode walks one strobe across every register, one per cycle, so the register file can be cleared after reset without a wide parallel clear. Optionally, the top index is treated as a hardwired zero register and is never strobed.

---
 rtl/en_decode_sweep_if.sv | 30 +++
 rtl/en_decode_sweep.sv | 84 ++++++++
 tb/tb_en_decode_sweep.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/en_decode_sweep_if.sv
// en_decode_sweep_if: groups the write-enable decoder's select/strobe signals.
//   in          : decode select (write address), SEL_W bits
//   enable      : decode enable
//   sweep_start : request a full clearing sweep
//   out         : registered one-hot (or all-zero) strobe vector, 2**SEL_W bits
//   sweep_busy  : sweep is issuing strobes
//   sweep_done  : one-cycle pulse at sweep completion
// master modport drives the request side; slave modport is the decoder.
interface en_decode_sweep_if #(
    parameter int SEL_W = 5
);
    localparam int OUT_N = 2 ** SEL_W;

    logic [SEL_W-1:0] in;
    logic             enable;
    logic             sweep_start;
    logic [OUT_N-1:0] out;
    logic             sweep_busy;
    logic             sweep_done;

    modport master (
        output in, enable, sweep_start,
        input  out, sweep_busy, sweep_done
    );

    modport slave (
        input  in, enable, sweep_start,
        output out, sweep_busy, sweep_done
    );
endinterface

// File: rtl/en_decode_sweep.sv
// en_decode_sweep: registered N-to-2^N enabled decoder for the register-file
// write-enable path, with a sweep mode that strobes every register once (one
// per cycle) so the file can be cleared after reset.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of en_decode_sweep_if (in/enable/sweep_start in,
//             out/sweep_busy/sweep_done out)
// Parameters:
//   SEL_W    : select width, OUT_N = 2**SEL_W strobes
//   ZERO_TOP : 1 = index OUT_N-1 is a hardwired zero register, never strobed
module en_decode_sweep #(
    parameter int SEL_W    = 5,
    parameter bit ZERO_TOP = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    en_decode_sweep_if.slave      bus
);
    localparam int OUT_N = 2 ** SEL_W;
    localparam int LAST  = ZERO_TOP ? OUT_N - 2 : OUT_N - 1;
    localparam int CNT_W = SEL_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [OUT_N-1:0] out_q, out_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            out_q <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            out_q <= out_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        out_n   = '0;
        unique case (state)
            SWEEP: begin
                // cnt always runs one ahead of the index currently on out,
                // so cnt == LAST+1 means onehot(LAST) is being driven now.
                if (cnt == CNT_W'(LAST + 1)) begin
                    state_n = DONE;
                    cnt_n   = '0;
                end else begin
                    out_n[cnt[SEL_W-1:0]] = 1'b1;
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            // DONE lasts one cycle; its outgoing edge applies the IDLE rule,
            // which lets a held sweep_start launch the next sweep at once.
            IDLE, DONE: begin
                state_n = IDLE;
                if (bus.sweep_start) begin
                    state_n  = SWEEP;
                    out_n[0] = 1'b1;
                    cnt_n    = CNT_W'(1);
                end else if (bus.enable &&
                             !(ZERO_TOP && (bus.in == {SEL_W{1'b1}}))) begin
                    out_n[bus.in] = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign bus.out        = out_q;
    assign bus.sweep_busy = (state == SWEEP);
    assign bus.sweep_done = (state == DONE);
endmodule

// File: tb/tb_en_decode_sweep.sv
// tb_en_decode_sweep: directed self-checking bench for en_decode_sweep.
// Three instances: SEL_W=2/ZERO_TOP=0, SEL_W=5/ZERO_TOP=1, SEL_W=5/ZERO_TOP=0.
module tb_en_decode_sweep;
    logic clk = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    en_decode_sweep_if #(.SEL_W(2)) b2 ();
    en_decode_sweep_if #(.SEL_W(5)) bz ();
    en_decode_sweep_if #(.SEL_W(5)) bn ();

    en_decode_sweep #(.SEL_W(2), .ZERO_TOP(1'b0)) u_d2 (
        .clk(clk), .reset_n(reset_n), .bus(b2.slave));
    en_decode_sweep #(.SEL_W(5), .ZERO_TOP(1'b1)) u_dz (
        .clk(clk), .reset_n(reset_n), .bus(bz.slave));
    en_decode_sweep #(.SEL_W(5), .ZERO_TOP(1'b0)) u_dn (
        .clk(clk), .reset_n(reset_n), .bus(bn.slave));

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        b2.in = '0; b2.enable = 1'b0; b2.sweep_start = 1'b0;
        bz.in = '0; bz.enable = 1'b0; bz.sweep_start = 1'b0;
        bn.in = '0; bn.enable = 1'b0; bn.sweep_start = 1'b0;
    endtask

    // Invariants on every cycle out of reset.
    logic prev_done_z = 1'b0, prev_done_n = 1'b0, prev_done_2 = 1'b0;
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            check("onehot_2", 32'($countones(b2.out) <= 1), 32'd1);
            check("onehot_z", 32'($countones(bz.out) <= 1), 32'd1);
            check("onehot_n", 32'($countones(bn.out) <= 1), 32'd1);
            check("done2x_2", 32'(prev_done_2 && b2.sweep_done), 32'd0);
            check("done2x_z", 32'(prev_done_z && bz.sweep_done), 32'd0);
            check("done2x_n", 32'(prev_done_n && bn.sweep_done), 32'd0);
        end
        prev_done_2 = b2.sweep_done;
        prev_done_z = bz.sweep_done;
        prev_done_n = bn.sweep_done;
    end

    // {in,enable} = 0..7 -> expected out for SEL_W=2
    logic [3:0] exp2 [8] = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8};

    initial begin
        logic [2:0] v;
        reset_n = 1'b0;
        idle_all();
        b2.enable = 1'b1; bz.enable = 1'b1; bz.in = 5'd4;
        tick();
        tick();
        check("rst_out_z",  bz.out, 32'h0);
        check("rst_out_2",  32'(b2.out), 32'h0);
        check("rst_busy_z", 32'(bz.sweep_busy), 32'h0);
        check("rst_done_z", 32'(bz.sweep_done), 32'h0);
        idle_all();
        #3 reset_n = 1'b1;
        tick();
        check("rel_out_z", bz.out, 32'h0);

        // Exhaustive decode, SEL_W=2
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            b2.in = v[2:1];
            b2.enable = v[0];
            tick();
            check("dec2", 32'(b2.out), 32'(exp2[i]));
        end
        b2.enable = 1'b0;

        // Zero-register mask
        bz.in = 5'd31; bz.enable = 1'b1;
        bn.in = 5'd31; bn.enable = 1'b1;
        tick();
        check("mask_z31", bz.out, 32'h0000_0000);
        check("nomask_n31", bn.out, 32'h8000_0000);
        bz.in = 5'd30;
        tick();
        check("mask_z30", bz.out, 32'h4000_0000);
        check("busy_idle", 32'(bz.sweep_busy), 32'h0);

        // Full sweep on both 5-bit instances, random enable/in meanwhile
        bz.sweep_start = 1'b1; bn.sweep_start = 1'b1;
        tick();
        bz.sweep_start = 1'b0; bn.sweep_start = 1'b0;
        check("sw_z0", bz.out, 32'h1);
        check("sw_n0", bn.out, 32'h1);
        check("sw_busy_z0", 32'(bz.sweep_busy), 32'h1);
        for (int i = 1; i <= 31; i++) begin
            bz.enable = 1'($urandom); bz.in = 5'($urandom);
            bn.enable = 1'($urandom); bn.in = 5'($urandom);
            if (i == 31) bz.enable = 1'b0;
            tick();
            check("sw_n", bn.out, 32'h1 << i);
            check("sw_busy_n", 32'(bn.sweep_busy), 32'h1);
            if (i <= 30) begin
                check("sw_z", bz.out, 32'h1 << i);
                check("sw_busy_z", 32'(bz.sweep_busy), 32'h1);
                check("sw_done_z", 32'(bz.sweep_done), 32'h0);
            end else begin
                check("end_z_out", bz.out, 32'h0);
                check("end_z_done", 32'(bz.sweep_done), 32'h1);
                check("end_z_busy", 32'(bz.sweep_busy), 32'h0);
            end
        end
        bn.enable = 1'b0;
        tick();
        check("post_z_out", bz.out, 32'h0);
        check("post_z_done", 32'(bz.sweep_done), 32'h0);
        check("end_n_out", bn.out, 32'h0);
        check("end_n_done", 32'(bn.sweep_done), 32'h1);
        check("end_n_busy", 32'(bn.sweep_busy), 32'h0);
        tick();
        check("post_n_done", 32'(bn.sweep_done), 32'h0);
        check("post_n_busy", 32'(bn.sweep_busy), 32'h0);

        // Collision, then back-to-back with sweep_start held through DONE
        bz.sweep_start = 1'b1; bz.enable = 1'b1; bz.in = 5'd3;
        tick();
        check("coll_out", bz.out, 32'h1);
        for (int i = 1; i <= 30; i++) tick();
        check("b2b_last", bz.out, 32'h4000_0000);
        tick();
        check("b2b_done", 32'(bz.sweep_done), 32'h1);
        tick();
        check("b2b_out", bz.out, 32'h1);
        check("b2b_busy", 32'(bz.sweep_busy), 32'h1);
        check("b2b_done0", 32'(bz.sweep_done), 32'h0);
        bz.sweep_start = 1'b0; bz.enable = 1'b0;

        // Advance to cnt=10 (out=onehot(9)), then reset between edges
        for (int i = 1; i <= 9; i++) tick();
        check("pre_rst", bz.out, 32'h200);
        #3 reset_n = 1'b0;
        #1;
        check("mid_rst_out", bz.out, 32'h0);
        check("mid_rst_busy", 32'(bz.sweep_busy), 32'h0);
        check("mid_rst_done", 32'(bz.sweep_done), 32'h0);
        #2 reset_n = 1'b1;
        bz.enable = 1'b1; bz.in = 5'd7;
        tick();
        check("rel_dec7", bz.out, 32'h80);
        check("rel_busy", 32'(bz.sweep_busy), 32'h0);
        bz.enable = 1'b0;
        tick();
        check("no_resume", bz.out, 32'h0);
        check("no_done", 32'(bz.sweep_done), 32'h0);

        // Random stimulus, invariants checked by the monitor
        for (int i = 0; i < 300; i++) begin
            b2.enable = 1'($urandom); b2.in = 2'($urandom);
            bz.enable = 1'($urandom); bz.in = 5'($urandom);
            bn.enable = 1'($urandom); bn.in = 5'($urandom);
            b2.sweep_start = ($urandom_range(0, 15) == 0);
            bz.sweep_start = ($urandom_range(0, 31) == 0);
            bn.sweep_start = ($urandom_range(0, 31) == 0);
            tick();
        end
        idle_all();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
